conv_spike_pool: RTL and testbench
==================================

# conv_spike_pool

Downstream stage of the convolution layer: consumes full-resolution output-spike events (one `OUT_CHANNELS`-wide spike vector per feature-map pixel) and performs 2x2 OR-pooling. Spikes are accumulated per pooling cell for the current timestep. On the timestep-end marker, the block scans all cells, emits one `output_vector_t`-shaped event per non-empty cell with halved coordinates, and then forwards the marker. It sits between the convolution core's spike generation and the next layer's input FIFO.

## Interface
Parameters:
- `IMG_WIDTH`, default 8: feature-map width; even power of two.
- `IMG_HEIGHT`, default 8: feature-map height; even, ≤ `IMG_WIDTH`.
- `OUT_CHANNELS`, default 2: spike vector width.
- `COORD_BITS`, default `$clog2(IMG_WIDTH)`: input coordinate width; output coordinates are `COORD_BITS-1`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  input event valid.
- `in_ready`  out  1  block can accept an input event.
- `in_timestep`  in  1  1 = timestep-end marker; `in_x`/`in_y`/`in_spikes` are ignored.
- `in_x`, `in_y`  in  `COORD_BITS`  pixel coordinate.
- `in_spikes`  in  `OUT_CHANNELS`  spike vector.
- `out_valid`  out  1  output event valid.
- `out_ready`  in  1  downstream accepts.
- `out_timestep`  out  1  1 = forwarded marker.
- `out_x`, `out_y`  out  `COORD_BITS-1`  pooled coordinate.
- `out_spikes`  out  `OUT_CHANNELS`  OR-pooled spike vector.
- `busy`  out  1  high in FLUSH or MARKER.

## Operation
- Storage: `NCELLS = (IMG_WIDTH/2)*(IMG_HEIGHT/2)` registers of `OUT_CHANNELS` bits.
- Cell index: `(y>>1)*(IMG_WIDTH/2) + (x>>1)`.
- States: ACCUM, FLUSH, MARKER.
- ACCUM:
  - `in_ready`=1.
  - A non-marker handshake ORs `in_spikes` into its cell.
  - `in_spikes`=0 is a no-op.
  - `in_y >= IMG_HEIGHT` is silently dropped.
  - A marker handshake sets scan index 0 and enters FLUSH.
- FLUSH:
  - `in_ready`=0.
  - If `cell[idx]`≠0: `out_valid`=1, `out_timestep`=0, `out_x=idx % (IMG_WIDTH/2)`, `out_y=idx / (IMG_WIDTH/2)`, `out_spikes=cell[idx]`. Hold until `out_ready`; on handshake clear the cell and advance the index.
  - If `cell[idx]`=0: `out_valid`=0 and the index advances.
  - After `idx = NCELLS-1` is advanced, go to MARKER.
- MARKER:
  - `out_valid`=1, `out_timestep`=1, `out_x`=`out_y`=0, `out_spikes`=0.
  - On handshake, go to ACCUM.
- Scan order is raster: row-major, x fastest.
- All outputs are driven from registered state only; there is no combinational path from `in_*` or `out_ready` to any output.
- Output fields are 0 whenever `out_valid`=0.
- After a flush, all cells are zero.

## Timing
- Reset values: state ACCUM, all cells 0, index 0, `out_valid`=0, `out_timestep`=0, `out_x`=`out_y`=`out_spikes`=0, `busy`=0. `in_ready`=0 during the reset cycle and 1 from the first cycle after.
- Accumulation: a spike accepted at edge k is visible in the cell at cycle k+1. Back-to-back same-cell events accumulate correctly every cycle.
- Flush with marker accepted at edge k and `out_ready` held 1:
  - FLUSH occupies cycles k+1 … k+NCELLS (one cell per cycle, empty or not).
  - The marker is presented at cycle k+NCELLS+1.
  - `in_ready` returns to 1 the cycle after the marker handshake.
  - For 8x8: 16 FLUSH cycles, marker at k+17, `in_ready` at k+18.
- Backpressure:
  - `out_ready`=0 stalls the scan; `out_*` stay stable while `out_valid`=1 and not accepted.
  - `out_valid` never drops without a handshake.
- Simultaneous events: none possible, since inputs are blocked outside ACCUM. `in_valid` held during FLUSH is accepted only after return to ACCUM.
- Reset mid-flush: the scan is abandoned, all cells are cleared, no marker is emitted, and the block returns to ACCUM.
- Empty timestep: only the marker is emitted, after NCELLS cycles.

## Test plan
- Reset, then single spike x=5, y=2, spikes=2'b01, then marker, `out_ready`=1 → exactly one event (x=2, y=1, spikes=01, ts=0) at cycle k+7, then marker (ts=1) at k+17; `in_ready` back at k+18.
- Four spikes in one cell — (0,0)=01, (1,0)=10, (0,1)=00, (1,1)=01 — then marker → one event x=0, y=0, spikes=11; cells all zero afterwards, so a second marker yields only a marker.
- Spikes in cells (3,3) and (0,0), then marker → events emitted in order (0,0) then (3,3); cell (3,3) output at cycle k+16.
- Backpressure: `out_ready` toggled 1010… during a flush of 3 non-empty cells → each event held stable until accepted, no loss or duplication, marker last.
- Spike accepted in the cycle `in_valid` coincides with `in_ready` rising after a marker → counted in the new timestep only.
- Assert `rst` mid-FLUSH with pending cells → no further outputs, no marker; the next marker yields only a marker.

Source files
------------

// File: rtl/conv_spike_pool.sv
// conv_spike_pool: 2x2 OR-pooling of per-pixel spike vectors.
// Spikes are accumulated per pooling cell. On a timestep-end marker the
// cells are scanned in raster order, one cell per cycle. Every non-empty
// cell is emitted, and then the marker itself is forwarded.
module conv_spike_pool #(
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int OUT_CHANNELS = 2,
  parameter int COORD_BITS   = $clog2(IMG_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_timestep,
  input  logic [COORD_BITS-1:0]   in_x,
  input  logic [COORD_BITS-1:0]   in_y,
  input  logic [OUT_CHANNELS-1:0] in_spikes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_timestep,
  output logic [COORD_BITS-2:0]   out_x,
  output logic [COORD_BITS-2:0]   out_y,
  output logic [OUT_CHANNELS-1:0] out_spikes,
  output logic                    busy
);

  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int NCELLS = HALF_W * (IMG_HEIGHT / 2);
  localparam int XB     = COORD_BITS - 1;
  // The width is a power of two, so a cell index is simply {y>>1, x>>1}.
  localparam int IDX_W  = 2 * XB;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NCELLS - 1);
  localparam logic [COORD_BITS:0] H_LIM    = (COORD_BITS + 1)'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_MARKER = 2'd2
  } state_t;

  typedef logic [NCELLS-1:0][OUT_CHANNELS-1:0] cells_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        scan_q, scan_d;
  cells_t                  cells_q, cells_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_ts_q, out_ts_d;
  logic [XB-1:0]           out_x_q, out_x_d;
  logic [XB-1:0]           out_y_q, out_y_d;
  logic [OUT_CHANNELS-1:0] out_spikes_q, out_spikes_d;

  logic [IDX_W-1:0]        in_idx_s;
  logic                    in_hs_s;
  logic                    in_y_ok_s;
  logic                    advance_s;
  logic [OUT_CHANNELS-1:0] next_cell_s;
  logic                    unused_s;

  // Select one cell of the storage array by scan index.
  function automatic logic [OUT_CHANNELS-1:0] cell_at(input cells_t cells,
                                                      input logic [IDX_W-1:0] idx);
    logic [OUT_CHANNELS-1:0] r;
    r = {OUT_CHANNELS{1'b0}};
    for (int i = 0; i < NCELLS; i++) begin
      if (idx == IDX_W'(i)) begin
        r = cells[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // The low coordinate bits only pick the pixel inside a 2x2 cell.
  assign unused_s = ^{in_x[0], in_y[0]};
  assign in_idx_s = {in_y[COORD_BITS-1:1], in_x[COORD_BITS-1:1]};
  assign in_y_ok_s = ({1'b0, in_y} < H_LIM);
  assign in_hs_s = in_valid && ready_q;

  // Compute the next state and cell contents, then derive next-cycle outputs from them.
  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    cells_d      = cells_q;
    advance_s    = 1'b0;
    out_valid_d  = 1'b0;
    out_ts_d     = 1'b0;
    out_x_d      = {XB{1'b0}};
    out_y_d      = {XB{1'b0}};
    out_spikes_d = {OUT_CHANNELS{1'b0}};
    case (state_q)
      ST_ACCUM: begin
        if (in_hs_s && in_timestep) begin
          state_d = ST_FLUSH;
          scan_d  = {IDX_W{1'b0}};
        end else if (in_hs_s && in_y_ok_s) begin
          for (int i = 0; i < NCELLS; i++) begin
            if (in_idx_s == IDX_W'(i)) begin
              cells_d[i] = cells_q[i] | in_spikes;
            end else begin
              cells_d[i] = cells_q[i];
            end
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_FLUSH: begin
        // A non-empty cell waits for the handshake; an empty one is skipped.
        if (out_valid_q) begin
          advance_s = out_ready;
        end else begin
          advance_s = 1'b1;
        end
        if (advance_s) begin
          for (int i = 0; i < NCELLS; i++) begin
            if (scan_q == IDX_W'(i)) begin
              cells_d[i] = {OUT_CHANNELS{1'b0}};
            end else begin
              cells_d[i] = cells_q[i];
            end
          end
          if (scan_q == LAST_IDX) begin
            state_d = ST_MARKER;
            scan_d  = {IDX_W{1'b0}};
          end else begin
            scan_d = scan_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          scan_d = scan_q;
        end
      end
      ST_MARKER: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_MARKER;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        scan_d  = {IDX_W{1'b0}};
      end
    endcase

    next_cell_s = cell_at(cells_d, scan_d);
    if ((state_d == ST_FLUSH) && (next_cell_s != {OUT_CHANNELS{1'b0}})) begin
      out_valid_d  = 1'b1;
      out_x_d      = scan_d[XB-1:0];
      out_y_d      = scan_d[IDX_W-1:XB];
      out_spikes_d = next_cell_s;
    end else if (state_d == ST_MARKER) begin
      out_valid_d = 1'b1;
      out_ts_d    = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
    ready_d = (state_d == ST_ACCUM);
    busy_d  = (state_d != ST_ACCUM);
  end

  // State, cell storage and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      scan_q       <= {IDX_W{1'b0}};
      cells_q      <= {(NCELLS*OUT_CHANNELS){1'b0}};
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ts_q     <= 1'b0;
      out_x_q      <= {XB{1'b0}};
      out_y_q      <= {XB{1'b0}};
      out_spikes_q <= {OUT_CHANNELS{1'b0}};
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      cells_q      <= cells_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_ts_q     <= out_ts_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_spikes_q <= out_spikes_d;
    end
  end

  // in_ready is held low while reset is applied.
  assign in_ready     = ready_q && !rst;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_timestep = out_ts_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_spikes   = out_spikes_q;

endmodule

// File: tb/tb_conv_spike_pool.sv
// Scoreboard bench for conv_spike_pool (8x8 map, 2 channels).
module tb_conv_spike_pool;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_timestep = 1'b0;
  logic [2:0] in_x = 3'd0;
  logic [2:0] in_y = 3'd0;
  logic [1:0] in_spikes = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_timestep;
  logic [1:0] out_x;
  logic [1:0] out_y;
  logic [1:0] out_spikes;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic toggle_en = 1'b0;

  typedef struct {
    logic       ts;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] sp;
    int         ecyc;
  } exp_t;
  exp_t sbq[$];

  logic       hold_pend = 1'b0;
  logic [6:0] hold_val;

  conv_spike_pool #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .OUT_CHANNELS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_timestep(in_timestep),
    .in_x(in_x), .in_y(in_y), .in_spikes(in_spikes),
    .out_valid(out_valid), .out_ready(out_ready), .out_timestep(out_timestep),
    .out_x(out_x), .out_y(out_y), .out_spikes(out_spikes), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Backpressure pattern 1,0,1,0... while enabled.
  always @(posedge clk) begin
    if (toggle_en) begin
      #1 out_ready = ~out_ready;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("held_valid", int'(out_valid), 1);
        chk("held_fields", int'({out_timestep, out_x, out_y, out_spikes}), int'(hold_val));
      end
      if (!out_valid) begin
        chk("idle_fields_zero", int'({out_timestep, out_x, out_y, out_spikes}), 0);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: ts=%0d x=%0d y=%0d sp=%0d cycle %0d",
                   out_timestep, out_x, out_y, out_spikes, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ev_ts", int'(out_timestep), int'(e.ts));
          chk("ev_x", int'(out_x), int'(e.x));
          chk("ev_y", int'(out_y), int'(e.y));
          chk("ev_spikes", int'(out_spikes), int'(e.sp));
          if (e.ecyc >= 0) begin
            chk("ev_cycle", cyc, e.ecyc);
          end
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_timestep, out_x, out_y, out_spikes};
    end
  end

  task automatic push(input logic ts, input int x, input int y, input int sp, input int ec);
    exp_t e;
    e.ts = ts; e.x = x[1:0]; e.y = y[1:0]; e.sp = sp[1:0]; e.ecyc = ec;
    sbq.push_back(e);
  endtask

  // Present one input event; k returns the cycle count after the accepting edge.
  task automatic send(input logic ts, input int x, input int y, input int sp, output int k);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_timestep = ts; in_x = x[2:0]; in_y = y[2:0]; in_spikes = sp[1:0];
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
    end
    #1;
    k = cyc;
    in_valid = 1'b0; in_timestep = 1'b0; in_spikes = 2'd0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sbq.size() != 0; n++) @(negedge clk);
    chk("drain_queue_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, k2, k3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_reset", int'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fields", int'({out_timestep, out_x, out_y, out_spikes}), 0);
    @(posedge clk);
    #1;

    // Single spike at (5,2): cell (2,1) = index 6.
    send(1'b0, 5, 2, 1, k);
    send(1'b1, 0, 0, 0, k);
    push(1'b0, 2, 1, 1, k + 6);
    push(1'b1, 0, 0, 0, k + 16);
    @(negedge clk);
    chk("flush_busy", int'(busy), 1);
    chk("flush_in_ready", int'(in_ready), 0);
    drain();

    // Four spikes in cell (0,0) OR together; second marker finds nothing.
    send(1'b0, 0, 0, 1, k);
    send(1'b0, 1, 0, 2, k);
    send(1'b0, 0, 1, 0, k);
    send(1'b0, 1, 1, 1, k);
    send(1'b1, 0, 0, 0, k);
    push(1'b0, 0, 0, 3, k);
    push(1'b1, 0, 0, 0, k + 16);
    drain();
    send(1'b1, 0, 0, 0, k);
    push(1'b1, 0, 0, 0, k + 16);
    drain();

    // Raster order: (3,3) is pushed first but (0,0) must come out first.
    send(1'b0, 6, 6, 2, k);
    send(1'b0, 1, 1, 1, k);
    send(1'b1, 0, 0, 0, k);
    push(1'b0, 0, 0, 1, k);
    push(1'b0, 3, 3, 2, k + 15);
    push(1'b1, 0, 0, 0, k + 16);
    drain();

    // Backpressure with out_ready toggling over three non-empty cells.
    send(1'b0, 2, 0, 3, k);
    send(1'b0, 0, 4, 1, k);
    send(1'b0, 7, 7, 2, k);
    toggle_en = 1'b1;
    send(1'b1, 0, 0, 0, k);
    push(1'b0, 1, 0, 3, -1);
    push(1'b0, 0, 2, 1, -1);
    push(1'b0, 3, 3, 2, -1);
    push(1'b1, 0, 0, 0, -1);
    drain();
    toggle_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;

    // Spike held during the flush is accepted the cycle in_ready returns.
    send(1'b0, 3, 3, 1, k);
    send(1'b1, 0, 0, 0, k);
    push(1'b0, 1, 1, 1, k + 5);
    push(1'b1, 0, 0, 0, k + 16);
    send(1'b0, 4, 0, 2, k2);
    chk("in_ready_return_cycle", k2, k + 18);
    send(1'b1, 0, 0, 0, k3);
    push(1'b0, 2, 0, 2, k3 + 2);
    push(1'b1, 0, 0, 0, k3 + 16);
    drain();

    // Reset in the middle of a stalled flush.
    out_ready = 1'b0;
    send(1'b0, 4, 4, 3, k);
    send(1'b0, 6, 6, 1, k);
    send(1'b1, 0, 0, 0, k);
    while (cyc < k + 12) @(negedge clk);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_out_x", int'(out_x), 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_out_valid", int'(out_valid), 0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    send(1'b1, 0, 0, 0, k);
    push(1'b1, 0, 0, 0, k + 16);
    drain();

    repeat (3) @(negedge clk);
    chk("final_queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
